signed_mul_top: RTL and testbench
=================================

Name: signed_mul_top

Overview:
- Registered 6x6 signed (two's-complement) multiplier producing the full 12-bit two's-complement product.
- Serves as the arithmetic leaf for multiply operations in the datapath.
- The combinational core is a radix-4 Booth partial-product generator feeding a carry-save adder tree and a final carry-propagate adder.
- The result is captured in an output register.

Parameters:
- WIDTH, 6: operand width in bits. Product width is 2*WIDTH. Must be even and at least 4.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- a  input  WIDTH  multiplicand, two's complement; bit WIDTH-1 is the sign
- b  input  WIDTH  multiplier, two's complement; bit WIDTH-1 is the sign
- out  output  2*WIDTH  registered product a*b, two's complement

Behaviour:
- Reset:
  - rst=1 forces out to all zeros immediately, without waiting for a clock edge.
  - out holds zero while rst is high.
  - The first capture happens on the first rising clk edge after rst deasserts.
- Latency and throughput:
  - 1 cycle latency. On each rising clk edge with rst=0, out <= product(a, b) sampled at that edge.
  - A new operand pair is accepted every cycle. There is no handshake.
  - Between edges, out is stable and glitch-free.
- Arithmetic:
  - out = signed(a) * signed(b), exact in 2*WIDTH bits. No overflow or saturation is possible.
  - For WIDTH=6, the operand range is -32..31 and the product range is -992..1024.
  - Equivalently, out = (a_int * b_int) mod 2^(2*WIDTH).
  - The most-negative case (-32)*(-32) = +1024 = 12'b010000000000 must be exact (positive, no sign wrap).
- Implementation structure:
  - Radix-4 Booth recoding of b gives WIDTH/2 digits in {-2,-1,0,+1,+2}. Each digit is formed from the triplet (b[2i+1], b[2i], b[2i-1]), with b[-1]=0.
  - Partial products are a, 2a, their negations (invert plus a correction bit injected at the LSB position), or zero.
  - Partial products are sign-extended to 2*WIDTH bits, or use the standard sign-extension-prevention constant; either scheme is acceptable.
  - Partial products are reduced with 3:2 carry-save adders, then a final 2*WIDTH-bit ripple or prefix adder.
  - The behavioural "*" operator is not used in the core.
  - The full core is combinational from a, b to the D input of the out register. No internal state other than out.
- Boundary conditions:
  - Zero operand on either side gives 0.
  - Sign combinations (+,+), (+,-), (-,+), (-,-) must all be exact.
  - Booth digit -2 with a = -32 (i.e. -2a = +64) must not overflow the partial-product width. Partial products are WIDTH+2 bits before extension.
  - Reset asserted mid-stream clears out asynchronously; the operands present at deassertion are captured at the next edge.
  - Operands changing at the same time as reset deasserts produce no X on out; out stays 0 until the next edge.

Test Plan:
- Reset: assert rst with a=31, b=31 -> out=12'h000 immediately. Deassert, one clk edge -> out=12'h3C1 (961).
- Extremes:
  - a=-32 (6'b100000), b=-32 -> out=12'h400 (1024) after 1 edge.
  - a=-32, b=31 -> out=12'hC20 (-992).
- Sign mix:
  - a=5, b=-3 -> 12'hFF1 (-15).
  - a=-1, b=1 -> 12'hFFF.
  - a=-1, b=-1 -> 12'h001.
  - a=0, b=-32 -> 12'h000.
- Pipelining: apply a new pair every cycle (3*4, -7*9, 31*-32) -> out shows 12'h00C, 12'hFC1, 12'hC20 on consecutive edges, each one cycle after its inputs.
- Exhaustive: all 4096 (a,b) pairs over -32..31 -> out == (a*b) & 12'hFFF for every pair. Zero mismatches required.
- Async reset mid-stream: pulse rst between clock edges while out=12'h3C1 -> out drops to 0 before the next edge and resumes correct products after deassertion.

Source files
------------

// File: rtl/signed_mul_if.sv
// Operand/result bundle for the registered signed multiplier.
// The master drives the operands and the slave returns the product.
interface signed_mul_if #(
  parameter int WIDTH = 6
);
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] out;

  modport master (output a, b, input out);
  modport slave  (input a, b, output out);
endinterface

// File: rtl/signed_mul_top.sv
// Registered WIDTH x WIDTH two's-complement multiplier with a 1-cycle latency.
// The core is radix-4 Booth partial products, a carry-save reduction, and a ripple adder.
module signed_mul_top #(
  parameter int WIDTH = 6
) (
  input  logic         clk,
  input  logic         rst,
  signed_mul_if.slave  bus
);
  localparam int PW  = 2 * WIDTH;  // product width
  localparam int NPP = WIDTH / 2;  // number of Booth digits
  localparam int PPW = WIDTH + 2;  // partial-product width, enough to hold +2^WIDTH

  logic [NPP:0][PW-1:0] rows;      // NPP partial products plus one row of negation bits
  logic [PW-1:0]        product;

  // Booth recoding and partial-product selection
  always_comb begin : booth_pp
    logic [PPW-1:0] a_ext;
    logic [PPW-1:0] a_dbl;
    logic [PPW-1:0] mag;
    logic [PPW-1:0] pp;
    logic [WIDTH:0] b_ext;
    logic [2:0]     trip;
    logic           neg;
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    rows  = '0;
    a_ext = {{2{bus.a[WIDTH-1]}}, bus.a};
    a_dbl = a_ext << 1;
    b_ext = {bus.b, 1'b0};
    mag   = '0;
    pp    = '0;
    trip  = '0;
    neg   = 1'b0;
    for (int i = 0; i < NPP; i++) begin
      trip = b_ext[2*i +: 3];
      case (trip)
        3'b001, 3'b010: begin mag = a_ext; neg = 1'b0; end
        3'b011:         begin mag = a_dbl; neg = 1'b0; end
        3'b100:         begin mag = a_dbl; neg = 1'b1; end
        3'b101, 3'b110: begin mag = a_ext; neg = 1'b1; end
        default:        begin mag = '0;    neg = 1'b0; end
      endcase
      // Negation is ones' complement here; the +1 goes into the correction row.
      pp              = neg ? ~mag : mag;
      rows[i]         = {{(PW-PPW){pp[PPW-1]}}, pp} << (2*i);
      rows[NPP][2*i]  = neg;
    end
  end

  // Linear 3:2 carry-save reduction followed by a ripple carry-propagate adder
  always_comb begin : reduce
    logic [PW-1:0] s;
    logic [PW-1:0] c;
    logic [PW-1:0] t;
    logic          cy;
    s       = rows[0];
    c       = rows[1];
    t       = '0;
    cy      = 1'b0;
    product = '0;
    for (int j = 2; j <= NPP; j++) begin
      t = s ^ c ^ rows[j];
      c = ((s & c) | (s & rows[j]) | (c & rows[j])) << 1;
      s = t;
    end
    for (int k = 0; k < PW; k++) begin
      product[k] = s[k] ^ c[k] ^ cy;
      cy         = (s[k] & c[k]) | (s[k] & cy) | (c[k] & cy);
    end
  end

  // NOTE: sequential state uses non-blocking assignments; combinational blocks above use blocking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.out <= '0;
    else     bus.out <= product;
  end
endmodule

// File: tb/tb_signed_mul_top.sv
// Scoreboard bench for signed_mul_top: expected products are queued when operands
// are driven and compared one clock edge later.
module tb_signed_mul_top;
  localparam int WIDTH = 6;
  localparam int PW    = 2 * WIDTH;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  logic [PW-1:0] exp_q[$];

  signed_mul_if #(.WIDTH(WIDTH)) bus ();

  signed_mul_top #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] model(input int x, input int y);
    int p;
    p = x * y;
    return p[PW-1:0];
  endfunction

  // Drive one operand pair at the falling edge, compare just after the next rising edge.
  task automatic apply(input int x, input int y, input string tag);
    @(negedge clk);
    bus.a = x[WIDTH-1:0];
    bus.b = y[WIDTH-1:0];
    exp_q.push_back(model(x, y));
    @(posedge clk);
    #1;
    check(tag, bus.out, exp_q.pop_front());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    bus.a = 6'd31;
    bus.b = 6'd31;
    #1;
    check("rst_async", bus.out, 12'h000);
    @(posedge clk);
    #1;
    check("rst_hold", bus.out, 12'h000);

    // Release reset; the operands already present are captured at the next edge.
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(12'h3C1);
    @(posedge clk);
    #1;
    check("rst_release", bus.out, exp_q.pop_front());

    apply(-32, -32, "neg32_sq");
    check("neg32_sq_const", bus.out, 12'h400);
    apply(-32,  31, "neg32_x31");
    check("neg32_x31_const", bus.out, 12'hC20);
    apply(  5,  -3, "pos_neg");
    check("pos_neg_const", bus.out, 12'hFF1);
    apply( -1,   1, "neg_pos");
    check("neg_pos_const", bus.out, 12'hFFF);
    apply( -1,  -1, "neg_neg");
    check("neg_neg_const", bus.out, 12'h001);
    apply(  0, -32, "zero_a");
    apply(-17,   0, "zero_b");

    // Back-to-back pairs, one per cycle
    apply(  3,   4, "pipe0");
    check("pipe0_const", bus.out, 12'h00C);
    apply( -7,   9, "pipe1");
    check("pipe1_const", bus.out, 12'hFC1);
    apply( 31, -32, "pipe2");
    check("pipe2_const", bus.out, 12'hC20);

    // Async clear between edges, with operands changing as reset drops
    apply(31, 31, "pre_clr");
    #2;
    rst = 1'b1;
    #1;
    check("async_clr", bus.out, 12'h000);
    #1;
    rst   = 1'b0;
    bus.a = 6'h3F;
    bus.b = 6'h3F;
    exp_q.push_back(model(-1, -1));
    #1;
    check("post_clr_hold", bus.out, 12'h000);
    @(posedge clk);
    #1;
    check("post_clr_capture", bus.out, exp_q.pop_front());

    for (int x = -32; x < 32; x++) begin
      for (int y = -32; y < 32; y++) begin
        apply(x, y, "exhaustive");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
